// File: rtl/cbfp1_sched.sv
// cbfp1_sched: control scheduler for a ping-pong CBFP block buffer.
// Write side: counts accepted input beats into the current bank and issues
// wr_en/mag_en/wr_addr. When a block completes, the bank is marked full and
// min_en is pulsed for it. Read side: a three-state FSM (IDLE/WAIT/READ)
// drains a full bank once its block-minimum shift has settled. The shift is
// ready MIN_LAT cycles after min_en. Reads are paced by out_ready.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   valid_in            input beat present
//   out_ready           downstream accepts a read beat
//   flush               synchronous clear of all state
//   mag_en              magnitude-detect enable (aligned with wr_en)
//   wr_en/bank/addr     buffer write strobe, bank, beat index
//   min_en/min_bank     block-minimum latch pulse and its bank
//   rd_en/bank/addr     buffer read strobe, bank, beat index
//   valid_out           rd_en delayed one cycle
//   blk_last            last beat of a block (with its rd_en)
//   busy                any bank full or any block in flight
//   ovf_err             sticky: a beat hit a full bank and was dropped
module cbfp1_sched #(
  parameter int unsigned BLK_CYC = 4,
  parameter int unsigned MIN_LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_in,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic                       mag_en,
  output logic                       wr_en,
  output logic                       wr_bank,
  output logic [$clog2(BLK_CYC)-1:0] wr_addr,
  output logic                       min_en,
  output logic                       min_bank,
  output logic                       rd_en,
  output logic                       rd_bank,
  output logic [$clog2(BLK_CYC)-1:0] rd_addr,
  output logic                       valid_out,
  output logic                       blk_last,
  output logic                       busy,
  output logic                       ovf_err
);

  localparam int unsigned AW = $clog2(BLK_CYC);
  localparam int unsigned LW = (MIN_LAT > 1) ? $clog2(MIN_LAT) : 1;
  localparam logic [AW-1:0] LAST     = AW'(BLK_CYC - 1);
  localparam logic [LW-1:0] LAT_INIT = LW'(MIN_LAT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, READ = 2'd2} state_t;

  // All state, including every output, lives in one record so that reset
  // and flush clear exactly the same set of registers.
  typedef struct packed {
    state_t               state;
    logic [AW-1:0]        wr_cnt;
    logic [AW-1:0]        rd_cnt;
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [1:0]           full;
    logic [1:0]           min_seen;
    logic [1:0][LW-1:0]   lat;
    logic                 wr_en;
    logic                 mag_en;
    logic                 wr_bank;
    logic [AW-1:0]        wr_addr;
    logic                 min_en;
    logic                 min_bank;
    logic                 rd_en;
    logic                 rd_bank;
    logic [AW-1:0]        rd_addr;
    logic                 valid_out;
    logic                 blk_last;
    logic                 busy;
    logic                 ovf_err;
  } regs_t;

  regs_t r, n;

  logic [1:0] lat_ok;
  logic       accept, wr_last, issue, rd_last, min_pulse, other;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r <= '0;
    end else if (flush) begin
      r <= '0;
    end else begin
      r <= n;
    end
  end

  always_comb begin
    n = r;
    for (int unsigned b = 0; b < 2; b++) begin
      lat_ok[b] = r.min_seen[b] && (r.lat[b] == '0);
    end

    // A full bank that is being drained can take a new beat whose slot has
    // already been read out. This lets continuous input overlap the tail of
    // the read without a false overflow.
    accept    = valid_in && (!r.full[r.wr_ptr] ||
                ((r.wr_ptr == r.rd_ptr) && (r.rd_cnt > r.wr_cnt)));
    wr_last   = accept && (r.wr_cnt == LAST);
    issue     = out_ready && ((r.state == READ) ||
                ((r.state == WAIT) && lat_ok[r.rd_ptr]));
    rd_last   = issue && (r.rd_cnt == LAST);
    min_pulse = r.wr_en && (r.wr_addr == LAST);
    other     = ~r.rd_ptr;

    // write side
    n.wr_en  = accept;
    n.mag_en = accept;
    if (accept) begin
      n.wr_addr = r.wr_cnt;
      n.wr_bank = r.wr_ptr;
      n.wr_cnt  = r.wr_cnt + AW'(1);
    end
    if (wr_last) begin
      n.wr_ptr           = ~r.wr_ptr;
      n.full[r.wr_ptr]   = 1'b1;
    end
    if (valid_in && !accept) n.ovf_err = 1'b1;

    // block-minimum pulse and per-bank settle countdown
    n.min_en = min_pulse;
    for (int unsigned b = 0; b < 2; b++) begin
      if (r.lat[b] != '0) n.lat[b] = r.lat[b] - LW'(1);
    end
    if (min_pulse) begin
      n.min_bank             = r.wr_bank;
      n.min_seen[r.wr_bank]  = 1'b1;
      n.lat[r.wr_bank]       = LAT_INIT;
    end

    // read side
    n.rd_en     = issue;
    n.blk_last  = rd_last;
    n.valid_out = r.rd_en;
    if (issue) begin
      n.rd_addr = r.rd_cnt;
      n.rd_bank = r.rd_ptr;
      n.rd_cnt  = r.rd_cnt + AW'(1);
    end
    if (rd_last) begin
      n.full[r.rd_ptr]     = 1'b0;
      n.min_seen[r.rd_ptr] = 1'b0;
      n.rd_ptr             = other;
    end

    case (r.state)
      IDLE:    if (r.full[r.rd_ptr]) n.state = WAIT;
      WAIT:    if (lat_ok[r.rd_ptr]) n.state = READ;
      READ:    n.state = READ;
      default: n.state = IDLE;
    endcase
    // Jumping straight to READ when the next bank has already settled keeps
    // the read stream free of bubbles.
    if (rd_last) begin
      if (n.full[other] && lat_ok[other]) n.state = READ;
      else if (n.full[other])             n.state = WAIT;
      else                                n.state = IDLE;
    end

    n.busy = (n.full != '0) || (n.state != IDLE) || (n.wr_cnt != '0) || issue;
  end

  assign mag_en    = r.mag_en;
  assign wr_en     = r.wr_en;
  assign wr_bank   = r.wr_bank;
  assign wr_addr   = r.wr_addr;
  assign min_en    = r.min_en;
  assign min_bank  = r.min_bank;
  assign rd_en     = r.rd_en;
  assign rd_bank   = r.rd_bank;
  assign rd_addr   = r.rd_addr;
  assign valid_out = r.valid_out;
  assign blk_last  = r.blk_last;
  assign busy      = r.busy;
  assign ovf_err   = r.ovf_err;

endmodule

// File: tb/tb_cbfp1_sched.sv
// Directed bench for cbfp1_sched (BLK_CYC=4, MIN_LAT=2). Cycle k begins at
// the k-th rising edge after reset release; outputs are sampled 1ns after
// that edge and the inputs for cycle k are driven right after sampling.
module tb_cbfp1_sched;
  logic       clk = 1'b0;
  logic       rst, valid_in, out_ready, flush;
  logic       mag_en, wr_en, wr_bank, min_en, min_bank, rd_en, rd_bank;
  logic [1:0] wr_addr, rd_addr;
  logic       valid_out, blk_last, busy, ovf_err;

  cbfp1_sched #(.BLK_CYC(4), .MIN_LAT(2)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .out_ready(out_ready),
    .flush(flush), .mag_en(mag_en), .wr_en(wr_en), .wr_bank(wr_bank),
    .wr_addr(wr_addr), .min_en(min_en), .min_bank(min_bank), .rd_en(rd_en),
    .rd_bank(rd_bank), .rd_addr(rd_addr), .valid_out(valid_out),
    .blk_last(blk_last), .busy(busy), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int sv[64], sr[64], sf[64];
  int t_we[64], t_me[64], t_wa[64], t_wb[64], t_mn[64], t_mb[64];
  int t_re[64], t_ra[64], t_rb[64], t_bl[64], t_vo[64], t_ovf[64], t_bsy[64];

  typedef struct {
    int v, r, we, wa, me, re, ra, bl, vo, bsy;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string name, input int c, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, got, exp);
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < 64; i++) begin
      sv[i] = 0; sr[i] = 1; sf[i] = 0;
    end
  endtask

  task automatic run(input int n);
    rst = 1'b1; valid_in = 1'b0; out_ready = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      t_we[k] = int'(wr_en);  t_me[k] = int'(mag_en); t_wa[k] = int'(wr_addr);
      t_wb[k] = int'(wr_bank); t_mn[k] = int'(min_en); t_mb[k] = int'(min_bank);
      t_re[k] = int'(rd_en);  t_ra[k] = int'(rd_addr); t_rb[k] = int'(rd_bank);
      t_bl[k] = int'(blk_last); t_vo[k] = int'(valid_out);
      t_ovf[k] = int'(ovf_err); t_bsy[k] = int'(busy);
      valid_in  = (sv[k] != 0);
      out_ready = (sr[k] != 0);
      flush     = (sf[k] != 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // single block, full per-cycle expectation table
    //            v  r  we wa me re ra bl vo bsy
    tbl[0]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 1};
    tbl[2]  = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 1};
    tbl[3]  = '{1, 1, 1, 2, 0, 0, 0, 0, 0, 1};
    tbl[4]  = '{0, 1, 1, 3, 0, 0, 0, 0, 0, 1};
    tbl[5]  = '{0, 1, 0, 3, 1, 0, 0, 0, 0, 1};
    tbl[6]  = '{0, 1, 0, 3, 0, 0, 0, 0, 0, 1};
    tbl[7]  = '{0, 1, 0, 3, 0, 1, 0, 0, 0, 1};
    tbl[8]  = '{0, 1, 0, 3, 0, 1, 1, 0, 1, 1};
    tbl[9]  = '{0, 1, 0, 3, 0, 1, 2, 0, 1, 1};
    tbl[10] = '{0, 1, 0, 3, 0, 1, 3, 1, 1, 1};
    tbl[11] = '{0, 1, 0, 3, 0, 0, 3, 0, 1, 0};
    tbl[12] = '{0, 1, 0, 3, 0, 0, 3, 0, 0, 0};
    clear_stim();
    for (int i = 0; i < 13; i++) begin
      sv[i] = tbl[i].v; sr[i] = tbl[i].r;
    end
    run(13);
    for (int c = 0; c < 13; c++) begin
      chk("t1 wr_en", c, t_we[c], tbl[c].we);
      chk("t1 mag_en", c, t_me[c], tbl[c].we);
      chk("t1 wr_addr", c, t_wa[c], tbl[c].wa);
      chk("t1 wr_bank", c, t_wb[c], 0);
      chk("t1 min_en", c, t_mn[c], tbl[c].me);
      chk("t1 rd_en", c, t_re[c], tbl[c].re);
      chk("t1 rd_addr", c, t_ra[c], tbl[c].ra);
      chk("t1 blk_last", c, t_bl[c], tbl[c].bl);
      chk("t1 valid_out", c, t_vo[c], tbl[c].vo);
      chk("t1 busy", c, t_bsy[c], tbl[c].bsy);
      chk("t1 ovf_err", c, t_ovf[c], 0);
    end

    // continuous input, four blocks, back-to-back reads
    clear_stim();
    for (int i = 0; i < 16; i++) sv[i] = 1;
    run(26);
    for (int c = 1; c <= 16; c++) begin
      chk("t2 wr_en", c, t_we[c], 1);
      chk("t2 wr_bank", c, t_wb[c], ((c - 1) / 4) % 2);
      chk("t2 wr_addr", c, t_wa[c], (c - 1) % 4);
    end
    for (int c = 0; c < 26; c++) begin
      int e_me, e_re, e_vo;
      e_me = (c >= 5 && c <= 17 && ((c - 5) % 4) == 0) ? 1 : 0;
      e_re = (c >= 7 && c <= 22) ? 1 : 0;
      e_vo = (c >= 8 && c <= 23) ? 1 : 0;
      chk("t2 min_en", c, t_mn[c], e_me);
      if (e_me == 1) chk("t2 min_bank", c, t_mb[c], ((c - 5) / 4) % 2);
      chk("t2 rd_en", c, t_re[c], e_re);
      chk("t2 valid_out", c, t_vo[c], e_vo);
      if (e_re == 1) begin
        chk("t2 rd_addr", c, t_ra[c], (c - 7) % 4);
        chk("t2 rd_bank", c, t_rb[c], ((c - 7) / 4) % 2);
        chk("t2 blk_last", c, t_bl[c], (((c - 7) % 4) == 3) ? 1 : 0);
      end
      chk("t2 ovf_err", c, t_ovf[c], 0);
    end

    // gapped input: one beat every other cycle
    clear_stim();
    sv[0] = 1; sv[2] = 1; sv[4] = 1; sv[6] = 1;
    run(16);
    for (int c = 0; c < 16; c++) begin
      int e_we, e_re;
      e_we = (c == 1 || c == 3 || c == 5 || c == 7) ? 1 : 0;
      e_re = (c >= 10 && c <= 13) ? 1 : 0;
      chk("t3 wr_en", c, t_we[c], e_we);
      if (e_we == 1) chk("t3 wr_addr", c, t_wa[c], (c - 1) / 2);
      chk("t3 min_en", c, t_mn[c], (c == 8) ? 1 : 0);
      chk("t3 rd_en", c, t_re[c], e_re);
      if (e_re == 1) chk("t3 rd_addr", c, t_ra[c], c - 10);
      chk("t3 blk_last", c, t_bl[c], (c == 13) ? 1 : 0);
    end

    // downstream stalled: both banks fill, overflow, then flush with a
    // valid beat in the same cycle, then a fresh block
    clear_stim();
    for (int i = 0; i < 12; i++) sv[i] = 1;
    for (int i = 13; i < 18; i++) sv[i] = 1;
    for (int i = 6; i < 64; i++) sr[i] = 0;
    sf[13] = 1;
    run(22);
    for (int c = 0; c < 22; c++) begin
      int e_we, e_me;
      e_we = ((c >= 1 && c <= 8) || (c >= 15 && c <= 18)) ? 1 : 0;
      e_me = (c == 5 || c == 9 || c == 19) ? 1 : 0;
      chk("t4 wr_en", c, t_we[c], e_we);
      if (e_we == 1 && c <= 8) begin
        chk("t4 wr_addr", c, t_wa[c], (c - 1) % 4);
        chk("t4 wr_bank", c, t_wb[c], (c - 1) / 4);
      end
      if (e_we == 1 && c >= 15) begin
        chk("t4 wr_addr", c, t_wa[c], c - 15);
        chk("t4 wr_bank", c, t_wb[c], 0);
      end
      chk("t4 min_en", c, t_mn[c], e_me);
      chk("t4 ovf_err", c, t_ovf[c], (c >= 9 && c <= 13) ? 1 : 0);
      chk("t4 rd_en", c, t_re[c], 0);
    end
    chk("t4 busy full", 12, t_bsy[12], 1);
    chk("t4 busy flushed", 14, t_bsy[14], 0);

    // one-cycle out_ready stall in the middle of a read
    clear_stim();
    for (int i = 0; i < 4; i++) sv[i] = 1;
    sr[8] = 0;
    run(14);
    begin
      int ra_e[6];
      ra_e = '{0, 1, 1, 2, 3, 3};
      for (int c = 6; c < 14; c++) begin
        chk("t5 rd_en", c, t_re[c], (c == 7 || c == 8 || c == 10 || c == 11) ? 1 : 0);
        chk("t5 valid_out", c, t_vo[c], (c == 8 || c == 9 || c == 11 || c == 12) ? 1 : 0);
        chk("t5 blk_last", c, t_bl[c], (c == 11) ? 1 : 0);
        if (c >= 7 && c <= 12) chk("t5 rd_addr", c, t_ra[c], ra_e[c - 7]);
      end
    end

    // asynchronous reset in the middle of a block
    clear_stim();
    for (int i = 0; i < 64; i++) sv[i] = 1;
    run(4);
    chk("t6 wr_en before rst", 3, t_we[3], 1);
    chk("t6 wr_addr before rst", 3, t_wa[3], 2);
    #2 rst = 1'b1;
    #1;
    chk("t6 wr_en async", 3, int'(wr_en), 0);
    chk("t6 mag_en async", 3, int'(mag_en), 0);
    chk("t6 wr_addr async", 3, int'(wr_addr), 0);
    chk("t6 busy async", 3, int'(busy), 0);
    @(posedge clk); #1;
    chk("t6 wr_en in rst", 4, int'(wr_en), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t6 wr_en after", 5, int'(wr_en), 1);
    chk("t6 wr_addr after", 5, int'(wr_addr), 0);
    chk("t6 wr_bank after", 5, int'(wr_bank), 0);
    chk("t6 ovf_err after", 5, int'(ovf_err), 0);
    valid_in = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
